// File: rtl/marine_radar_pulse_sequencer.sv
// Marine radar pulse sequencer: on an accepted trigger, waits trig_delay
// cycles, emits a 4-word header (trigger count, ACP count, ARP count) and
// then n_samples decimated video samples to a downstream FIFO.
// Handshake: out_strobe is a one-cycle valid with no ready; the FIFO signals
// back-pressure only through fifo_full, which aborts the packet (overrun).
module marine_radar_pulse_sequencer (
    input  logic        master_clk,
    input  logic        reset_n,
    input  logic        enable_rx,
    input  logic [15:0] decim_rate,
    input  logic [15:0] trig_delay,
    input  logic [15:0] n_samples,
    input  logic [2:0]  marine_radar_mode,
    input  logic        new_mode,
    input  logic        trig_pulse,
    input  logic        ACP_pulse,
    input  logic        ARP_pulse,
    input  logic [15:0] sample_in,
    input  logic        fifo_full,
    output logic [15:0] out_data,
    output logic        out_strobe,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DELAY   = 2'd1,
        S_HEADER  = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dly_q, dly_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] dec_q, dec_d;
    logic [15:0] smp_q, smp_d;
    logic [31:0] trig_count_q, trig_count_d;
    logic [15:0] acp_count_q, acp_count_d;
    logic [15:0] arp_count_q, arp_count_d;
    logic [31:0] trig_snap_q, trig_snap_d;
    logic [15:0] acp_snap_q, acp_snap_d;
    logic [15:0] arp_snap_q, arp_snap_d;
    logic        test_mode_q, test_mode_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_strobe_q, out_strobe_d;
    logic        overrun_q, overrun_d;

    logic [15:0] decim_eff;
    logic [15:0] hdr_word;
    logic        mode_active;
    logic        last_sample;

    assign decim_eff   = (decim_rate == 16'd0) ? 16'd1 : decim_rate;
    assign mode_active = (marine_radar_mode == 3'd1) || (marine_radar_mode == 3'd2);
    // Wide compare so a shrinking n_samples mid-packet still terminates.
    assign last_sample = ({1'b0, smp_q} + 17'd1) >= {1'b0, n_samples};

    // Header word selected by the running header index.
    always_comb begin
        hdr_word = trig_snap_q[15:0];
        case (hdr_idx_q)
            2'd0:    hdr_word = trig_snap_q[15:0];
            2'd1:    hdr_word = trig_snap_q[31:16];
            2'd2:    hdr_word = acp_snap_q;
            default: hdr_word = arp_snap_q;
        endcase
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        hdr_idx_d    = hdr_idx_q;
        dec_d        = dec_q;
        smp_d        = smp_q;
        trig_count_d = trig_count_q;
        acp_count_d  = acp_count_q;
        arp_count_d  = arp_count_q;
        trig_snap_d  = trig_snap_q;
        acp_snap_d   = acp_snap_q;
        arp_snap_d   = arp_snap_q;
        test_mode_d  = test_mode_q;
        out_data_d   = out_data_q;
        out_strobe_d = 1'b0;
        overrun_d    = overrun_q;

        // Event counters run independently of the FSM.
        if (trig_pulse && enable_rx) begin
            trig_count_d = trig_count_q + 32'd1;
        end
        if (ARP_pulse) begin
            acp_count_d = ACP_pulse ? 16'd1 : 16'd0;
            arp_count_d = arp_count_q + 16'd1;
        end else if (ACP_pulse) begin
            acp_count_d = acp_count_q + 16'd1;
        end

        if (!enable_rx || new_mode) begin
            state_d = S_IDLE;
            if (new_mode) begin
                overrun_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trig_pulse && mode_active) begin
                        trig_snap_d = trig_count_q + 32'd1;
                        acp_snap_d  = acp_count_q;
                        arp_snap_d  = arp_count_q;
                        test_mode_d = (marine_radar_mode == 3'd2);
                        hdr_idx_d   = 2'd0;
                        dly_d       = trig_delay;
                        state_d     = (trig_delay == 16'd0) ? S_HEADER : S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (dly_q == 16'd1) begin
                        state_d = S_HEADER;
                    end else begin
                        dly_d = dly_q - 16'd1;
                    end
                end
                S_HEADER: begin
                    if (fifo_full) begin
                        overrun_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        out_strobe_d = 1'b1;
                        out_data_d   = hdr_word;
                        if (hdr_idx_q == 2'd3) begin
                            dec_d   = 16'd0;
                            smp_d   = 16'd0;
                            state_d = (n_samples == 16'd0) ? S_IDLE : S_CAPTURE;
                        end else begin
                            hdr_idx_d = hdr_idx_q + 2'd1;
                        end
                    end
                end
                default: begin
                    if (dec_q == 16'd0) begin
                        if (fifo_full) begin
                            overrun_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            out_strobe_d = 1'b1;
                            out_data_d   = test_mode_q ? smp_q : sample_in;
                            smp_d        = smp_q + 16'd1;
                            dec_d        = decim_eff - 16'd1;
                            if (last_sample) begin
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        dec_d = dec_q - 16'd1;
                    end
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge master_clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            dly_q        <= '0;
            hdr_idx_q    <= '0;
            dec_q        <= '0;
            smp_q        <= '0;
            trig_count_q <= '0;
            acp_count_q  <= '0;
            arp_count_q  <= '0;
            trig_snap_q  <= '0;
            acp_snap_q   <= '0;
            arp_snap_q   <= '0;
            test_mode_q  <= 1'b0;
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            hdr_idx_q    <= hdr_idx_d;
            dec_q        <= dec_d;
            smp_q        <= smp_d;
            trig_count_q <= trig_count_d;
            acp_count_q  <= acp_count_d;
            arp_count_q  <= arp_count_d;
            trig_snap_q  <= trig_snap_d;
            acp_snap_q   <= acp_snap_d;
            arp_snap_q   <= arp_snap_d;
            test_mode_q  <= test_mode_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_strobe = out_strobe_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_marine_radar_pulse_sequencer.sv
// Directed testbench for marine_radar_pulse_sequencer. Inputs change and
// outputs are sampled 1 ns after each rising edge. Edge count t is 0 at the
// edge that samples the trigger; sample_in is 16'h5000 + t after edge t, so
// a sample strobed at edge t carries 16'h5000 + t - 1.
module tb_marine_radar_pulse_sequencer;

    logic        master_clk = 1'b0;
    logic        reset_n;
    logic        enable_rx;
    logic [15:0] decim_rate;
    logic [15:0] trig_delay;
    logic [15:0] n_samples;
    logic [2:0]  marine_radar_mode;
    logic        new_mode;
    logic        trig_pulse;
    logic        ACP_pulse;
    logic        ARP_pulse;
    logic [15:0] sample_in;
    logic        fifo_full;
    logic [15:0] out_data;
    logic        out_strobe;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int t = 0;
    logic [15:0] got_q[$];
    int          got_t[$];
    logic [15:0] exp_q[$];
    int          exp_t[$];

    marine_radar_pulse_sequencer dut (
        .master_clk        (master_clk),
        .reset_n           (reset_n),
        .enable_rx         (enable_rx),
        .decim_rate        (decim_rate),
        .trig_delay        (trig_delay),
        .n_samples         (n_samples),
        .marine_radar_mode (marine_radar_mode),
        .new_mode          (new_mode),
        .trig_pulse        (trig_pulse),
        .ACP_pulse         (ACP_pulse),
        .ARP_pulse         (ARP_pulse),
        .sample_in         (sample_in),
        .fifo_full         (fifo_full),
        .out_data          (out_data),
        .out_strobe        (out_strobe),
        .busy              (busy),
        .overrun           (overrun)
    );

    // Clock and reset
    always #5 master_clk = ~master_clk;

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) begin
            @(posedge master_clk);
            #1;
        end
        reset_n = 1'b1;
    endtask

    // Driver tasks
    task automatic collect(input int n);
        repeat (n) begin
            @(posedge master_clk);
            #1;
            t++;
            sample_in = 16'h5000 + 16'(t);
            if (out_strobe) begin
                got_q.push_back(out_data);
                got_t.push_back(t);
            end
        end
    endtask

    task automatic fire();
        got_q.delete();
        got_t.delete();
        trig_pulse = 1'b1;
        @(posedge master_clk);
        #1;
        trig_pulse = 1'b0;
        t = 0;
        sample_in = 16'h5000;
    endtask

    task automatic pulse_az(input logic acp, input logic arp);
        ACP_pulse = acp;
        ARP_pulse = arp;
        @(posedge master_clk);
        #1;
        ACP_pulse = 1'b0;
        ARP_pulse = 1'b0;
        @(posedge master_clk);
        #1;
    endtask

    task automatic config_pkt(input logic [2:0] m, input logic [15:0] dly,
                              input logic [15:0] dec, input logic [15:0] n);
        marine_radar_mode = m;
        trig_delay        = dly;
        decim_rate        = dec;
        n_samples         = n;
    endtask

    // Scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge master_clk);
        #1;
        checks++;
        if (out_strobe !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: strobe=%b data=%h busy=%b overrun=%b, required 0/0000/0/0",
                     out_strobe, out_data, busy, overrun);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_normal();
        do_reset();
        config_pkt(3'd1, 16'd3, 16'd2, 16'd4);
        fire();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL normal_busy_after_trig: busy=%b, required 1", busy);
        end
        collect(13);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL normal_busy_before_last: busy=%b, required 1", busy);
        end
        collect(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL normal_busy_after_last: busy=%b, required 0", busy);
        end
        collect(6);
        exp_q = '{16'd1, 16'd0, 16'd0, 16'd0, 16'h5007, 16'h5009, 16'h500B, 16'h500D};
        exp_t = '{4, 5, 6, 7, 8, 10, 12, 14};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL normal_count: %0d strobes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++;
                $display("FAIL normal_word%0d: missing, required %h at t=%0d", i, exp_q[i], exp_t[i]);
            end else if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
                errors++;
                $display("FAIL normal_word%0d: %h at t=%0d, required %h at t=%0d",
                         i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_acp_arp();
        do_reset();
        repeat (5) pulse_az(1'b1, 1'b0);
        pulse_az(1'b1, 1'b1);
        repeat (2) pulse_az(1'b1, 1'b0);
        config_pkt(3'd1, 16'd0, 16'd1, 16'd0);
        fire();
        collect(8);
        exp_q = '{16'd1, 16'd0, 16'd3, 16'd1};
        exp_t = '{1, 2, 3, 4};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL acp_count: %0d strobes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++;
                $display("FAIL acp_word%0d: missing, required %h at t=%0d", i, exp_q[i], exp_t[i]);
            end else if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
                errors++;
                $display("FAIL acp_word%0d: %h at t=%0d, required %h at t=%0d",
                         i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL acp_nsamples0_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_mode2();
        do_reset();
        config_pkt(3'd2, 16'd0, 16'd0, 16'd3);
        fire();
        collect(12);
        exp_q = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2};
        exp_t = '{1, 2, 3, 4, 5, 6, 7};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mode2_count: %0d strobes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++;
                $display("FAIL mode2_word%0d: missing, required %h at t=%0d", i, exp_q[i], exp_t[i]);
            end else if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
                errors++;
                $display("FAIL mode2_word%0d: %h at t=%0d, required %h at t=%0d",
                         i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        config_pkt(3'd1, 16'd0, 16'd1, 16'd4);
        fire();
        collect(5);
        fifo_full = 1'b1;
        collect(1);
        fifo_full = 1'b0;
        checks++;
        if (out_strobe !== 1'b0 || overrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_event: strobe=%b overrun=%b busy=%b, required 0/1/0",
                     out_strobe, overrun, busy);
        end
        collect(4);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
        end
        exp_q = '{16'd1, 16'd0, 16'd0, 16'd0, 16'h5004};
        exp_t = '{1, 2, 3, 4, 5};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL overrun_count: %0d strobes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++;
                $display("FAIL overrun_word%0d: missing, required %h at t=%0d", i, exp_q[i], exp_t[i]);
            end else if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
                errors++;
                $display("FAIL overrun_word%0d: %h at t=%0d, required %h at t=%0d",
                         i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
        end
        new_mode = 1'b1;
        collect(1);
        new_mode = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        config_pkt(3'd1, 16'd0, 16'd1, 16'd4);
        fire();
        collect(5);
        trig_pulse = 1'b1;
        collect(1);
        trig_pulse = 1'b0;
        collect(8);
        exp_q = '{16'd1, 16'd0, 16'd0, 16'd0, 16'h5004, 16'h5005, 16'h5006, 16'h5007};
        exp_t = '{1, 2, 3, 4, 5, 6, 7, 8};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: %0d strobes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++;
                $display("FAIL b2b_word%0d: missing, required %h at t=%0d", i, exp_q[i], exp_t[i]);
            end else if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
                errors++;
                $display("FAIL b2b_word%0d: %h at t=%0d, required %h at t=%0d",
                         i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
        end
        fire();
        collect(3);
        checks++;
        if (got_q.size() < 2 || got_q[0] !== 16'd3 || got_q[1] !== 16'd0) begin
            errors++;
            $display("FAIL b2b_trig_count: %0d words, first=%h, required 0003 then 0000",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_abort();
        do_reset();
        config_pkt(3'd1, 16'd5, 16'd1, 16'd4);
        fire();
        collect(2);
        enable_rx = 1'b0;
        collect(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_enable_busy: busy=%b, required 0", busy);
        end
        enable_rx = 1'b1;
        collect(10);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL abort_no_words: %0d strobes, required 0", got_q.size());
        end
        marine_radar_mode = 3'd0;
        fire();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mode_off_ignored: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_az(1'b1, 1'b0);
        pulse_az(1'b1, 1'b0);
        pulse_az(1'b0, 1'b1);
        pulse_az(1'b1, 1'b0);
        config_pkt(3'd1, 16'd0, 16'd1, 16'd4);
        fire();
        collect(6);
        checks++;
        if (got_q.size() < 4 || got_q[2] !== 16'd1 || got_q[3] !== 16'd1) begin
            errors++;
            $display("FAIL rmid_pre_header: %0d words, required ACP=0001 ARP=0001", got_q.size());
        end
        reset_n = 1'b0;
        collect(1);
        checks++;
        if (out_strobe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_truncate: strobe=%b busy=%b, required 0/0", out_strobe, busy);
        end
        reset_n = 1'b1;
        fire();
        collect(4);
        exp_q = '{16'd1, 16'd0, 16'd0, 16'd0};
        exp_t = '{1, 2, 3, 4};
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++;
                $display("FAIL rmid_word%0d: missing, required %h at t=%0d", i, exp_q[i], exp_t[i]);
            end else if (got_q[i] !== exp_q[i] || got_t[i] != exp_t[i]) begin
                errors++;
                $display("FAIL rmid_word%0d: %h at t=%0d, required %h at t=%0d",
                         i, got_q[i], got_t[i], exp_q[i], exp_t[i]);
            end
        end
    endtask

    // Sequence and final report
    initial begin
        reset_n           = 1'b0;
        enable_rx         = 1'b1;
        decim_rate        = 16'd1;
        trig_delay        = 16'd0;
        n_samples         = 16'd0;
        marine_radar_mode = 3'd0;
        new_mode          = 1'b0;
        trig_pulse        = 1'b0;
        ACP_pulse         = 1'b0;
        ARP_pulse         = 1'b0;
        sample_in         = 16'h0;
        fifo_full         = 1'b0;
        test_reset();
        test_normal();
        test_acp_arp();
        test_mode2();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
